ni_packet_injector: RTL and testbench

- Tile-side NoC injection engine. Converts a beat stream from the tile (first/last framed, destination core id) into header/body/tail flits on the router local port.
- Allocates a virtual channel per packet and tracks per-VC credits.
- Generalises the fixed 3x3, 2-VC flit wiring to any NX/NY/V/B/Fpay, with credit flow control, destination range checking and status counters.

---
 rtl/ni_packet_injector.sv | 213 +++++++++++++++++++++
 tb/tb_ni_packet_injector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packet_injector.sv
// Tile-side NoC injector: frames tile beats into header/body/tail flits, allocates a VC
// per packet round-robin and tracks per-VC credits against the router input buffers.

module ni_vc_credit #(
  parameter int B  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sent_i,
  input  logic          credit_i,
  output logic [CW-1:0] cnt_o,
  output logic          ovf_o
);
  localparam logic [CW-1:0] FULL = CW'(B);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (sent_i && !credit_i) cnt_d = cnt_q - CW'(1);
    else if (credit_i && !sent_i) begin
      // A return with the buffer already fully credited is a protocol error; saturate.
      if (cnt_q == FULL) ovf_o = 1'b1;
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= FULL;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module ni_packet_injector #(
  parameter int NX   = 3,
  parameter int NY   = 3,
  parameter int V    = 2,
  parameter int B    = 4,
  parameter int Fpay = 32,
  parameter int CNTw = 16,
  localparam int NC  = NX * NY,
  localparam int Xw  = (NX > 1) ? $clog2(NX) : 1,
  localparam int Yw  = (NY > 1) ? $clog2(NY) : 1,
  localparam int NCw = (NC > 1) ? $clog2(NC) : 1,
  localparam int Fw  = 2 + V + Fpay
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Xw-1:0]   current_x,
  input  logic [Yw-1:0]   current_y,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [Fpay-1:0] s_data,
  input  logic            s_first,
  input  logic            s_last,
  input  logic [NCw-1:0]  s_dest,
  output logic [Fw-1:0]   flit_out,
  output logic            flit_out_wr,
  input  logic [V-1:0]    credit_in,
  output logic            busy,
  output logic            err_dest,
  output logic            err_frame,
  output logic [CNTw-1:0] pkt_cnt
);
  localparam int CW  = $clog2(B + 1);
  localparam int VIw = (V > 1) ? $clog2(V) : 1;
  localparam int LOW = 2 * (Xw + Yw);
  localparam int VM1 = V - 1;
  localparam logic [VIw:0]   VSZ   = V[VIw:0];
  localparam logic [VIw-1:0] VLAST = VM1[VIw-1:0];

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

  state_t            state_q, state_d;
  logic [V-1:0]      vc_q, vc_d;
  logic [VIw-1:0]    rr_q, rr_d;
  logic [Fw-1:0]     flit_q, flit_d;
  logic              wr_q, wr_d;
  logic              err_dest_q, err_dest_d;
  logic              err_frame_q, err_frame_d;
  logic [CNTw-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic [V-1:0][CW-1:0] cnt;
  logic [V-1:0]         avail, ovf, sent_vc;

  for (genvar g = 0; g < V; g++) begin : g_vc
    ni_vc_credit #(.B(B), .CW(CW)) u_credit (
      .clk      (clk),
      .reset    (reset),
      .sent_i   (sent_vc[g]),
      .credit_i (credit_in[g]),
      .cnt_o    (cnt[g]),
      .ovf_o    (ovf[g])
    );
    assign avail[g] = |cnt[g];
  end

  // Destination decode and header payload (routing fields overwrite the low payload bits).
  logic [NCw-1:0]  dx_full, dy_full;
  logic            dest_bad;
  logic [Fpay-1:0] hdr_pay;

  always_comb begin
    dx_full  = s_dest % NCw'(NX);
    dy_full  = s_dest / NCw'(NX);
    dest_bad = {{(32-NCw){1'b0}}, s_dest} >= 32'(NC);
    hdr_pay  = s_data;
    hdr_pay[LOW-1:0] = {current_y, current_x, dy_full[Yw-1:0], dx_full[Xw-1:0]};
  end

  // Round-robin grant: rotate availability so the pointer VC is bit 0, take the lowest set.
  logic [2*V-1:0] avail2;
  logic [V-1:0]   rot, gnt_oh;
  logic [VIw-1:0] gnt_off, gnt_idx, rr_nxt;
  logic [VIw:0]   gsum;

  always_comb begin
    avail2  = {avail, avail};
    rot     = avail2[rr_q +: V];
    gnt_off = '0;
    for (int k = V - 1; k >= 0; k--) if (rot[k]) gnt_off = VIw'(k);
    gsum    = {1'b0, rr_q} + {1'b0, gnt_off};
    gnt_idx = (gsum >= VSZ) ? VIw'(gsum - VSZ) : gsum[VIw-1:0];
    rr_nxt  = (gnt_idx == VLAST) ? '0 : gnt_idx + VIw'(1);
    gnt_oh  = '0;
    gnt_oh[gnt_idx] = 1'b1;
  end

  always_comb begin
    case (state_q)
      IDLE:    s_ready = (|avail) | ~s_first;
      SEND:    s_ready = |(vc_q & avail);
      DROP:    s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  logic acc;
  assign acc = s_valid & s_ready;

  always_comb begin
    state_d     = state_q;
    vc_d        = vc_q;
    rr_d        = rr_q;
    flit_d      = flit_q;
    wr_d        = 1'b0;
    err_dest_d  = err_dest_q;
    err_frame_d = err_frame_q | (|ovf);
    pkt_cnt_d   = pkt_cnt_q;
    sent_vc     = '0;
    case (state_q)
      IDLE: if (acc) begin
        if (!s_first) err_frame_d = 1'b1;
        else if (dest_bad) begin
          err_dest_d = 1'b1;
          if (!s_last) state_d = DROP;
        end else begin
          vc_d    = gnt_oh;
          rr_d    = rr_nxt;
          flit_d  = {1'b1, s_last, gnt_oh, hdr_pay};
          wr_d    = 1'b1;
          sent_vc = gnt_oh;
          if (s_last) pkt_cnt_d = pkt_cnt_q + CNTw'(1);
          else        state_d   = SEND;
        end
      end
      SEND: if (acc) begin
        flit_d  = {1'b0, s_last, vc_q, s_data};
        wr_d    = 1'b1;
        sent_vc = vc_q;
        if (s_last) begin
          pkt_cnt_d = pkt_cnt_q + CNTw'(1);
          state_d   = IDLE;
        end
      end
      DROP: if (acc && s_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vc_q        <= '0;
      rr_q        <= '0;
      flit_q      <= '0;
      wr_q        <= 1'b0;
      err_dest_q  <= 1'b0;
      err_frame_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      vc_q        <= vc_d;
      rr_q        <= rr_d;
      flit_q      <= flit_d;
      wr_q        <= wr_d;
      err_dest_q  <= err_dest_d;
      err_frame_q <= err_frame_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign flit_out    = flit_q;
  assign flit_out_wr = wr_q;
  assign busy        = (state_q != IDLE);
  assign err_dest    = err_dest_q;
  assign err_frame   = err_frame_q;
  assign pkt_cnt     = pkt_cnt_q;
endmodule

// File: tb/tb_ni_packet_injector.sv
// Scoreboard bench: a packet-level model predicts flits, ready and status; a monitor
// pops expected flits whenever the injector writes one.
module tb_ni_packet_injector;
  localparam int NX = 3, NY = 3, V = 2, B = 4, FPAY = 32, CNTW = 16;
  localparam int NC = NX * NY, XW = $clog2(NX), YW = $clog2(NY), NCW = $clog2(NC);
  localparam int FW = 2 + V + FPAY, LOW = 2 * (XW + YW);

  logic            clk = 1'b0, reset = 1'b1;
  logic [XW-1:0]   cur_x = '0;
  logic [YW-1:0]   cur_y = '0;
  logic            s_valid = 1'b0, s_ready, s_first = 1'b0, s_last = 1'b0;
  logic [FPAY-1:0] s_data = '0;
  logic [NCW-1:0]  s_dest = '0;
  logic [FW-1:0]   flit_out;
  logic            flit_out_wr, busy, err_dest, err_frame;
  logic [V-1:0]    credit_in = '0;
  logic [CNTW-1:0] pkt_cnt;

  ni_packet_injector #(.NX(NX), .NY(NY), .V(V), .B(B), .Fpay(FPAY), .CNTw(CNTW)) dut (
    .clk(clk), .reset(reset), .current_x(cur_x), .current_y(cur_y),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_first(s_first),
    .s_last(s_last), .s_dest(s_dest), .flit_out(flit_out), .flit_out_wr(flit_out_wr),
    .credit_in(credit_in), .busy(busy), .err_dest(err_dest), .err_frame(err_frame),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_wr = 0;

  // Reference model: packet state (0 idle, 1 sending, 2 dropping), credits, RR pointer.
  int            mstate, mrr, mvc, mpkt;
  int            mcnt[V];
  bit            merr_dest, merr_frame;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (flit_out_wr === 1'b1) begin
      n_wr++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_flit: got %0h expected none at %0t", flit_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        n_chk--;
        chk("flit", 64'(flit_out), 64'(mon_e));
      end
    end
  end

  function automatic logic [FW-1:0] mk_flit(bit hdr, bit tail, int vc, logic [31:0] pay);
    logic [V-1:0] oh;
    oh = '0;
    oh[vc] = 1'b1;
    return {hdr, tail, oh, pay};
  endfunction

  function automatic logic [31:0] hdr_pay(logic [31:0] d, int dst);
    logic [31:0] low, mask;
    low  = 32'(dst % NX) | (32'(dst / NX) << XW) | (32'(cur_x) << (XW + YW))
         | (32'(cur_y) << (2 * XW + YW));
    mask = (32'h1 << LOW) - 32'h1;
    return (d & ~mask) | (low & mask);
  endfunction

  function automatic bit m_ready(bit first);
    if (mstate == 1) return mcnt[mvc] > 0;
    if (mstate == 2) return 1'b1;
    for (int k = 0; k < V; k++) if (mcnt[k] > 0) return 1'b1;
    return !first;
  endfunction

  task automatic m_reset();
    mstate = 0; mrr = 0; mvc = 0; mpkt = 0; merr_dest = 0; merr_frame = 0;
    for (int k = 0; k < V; k++) mcnt[k] = B;
    exp_q.delete();
  endtask

  task automatic m_step(bit acc, logic [31:0] d, bit f, bit l, int dst, logic [V-1:0] cr);
    int sent, g, c;
    sent = -1;
    g = -1;
    if (acc) begin
      if (mstate == 0) begin
        if (!f) merr_frame = 1;
        else if (dst >= NC) begin
          merr_dest = 1;
          if (!l) mstate = 2;
        end else begin
          for (int k = 0; k < V; k++) begin
            c = (mrr + k) % V;
            if (g < 0 && mcnt[c] > 0) g = c;
          end
          mvc = g;
          mrr = (g + 1) % V;
          exp_q.push_back(mk_flit(1, l, g, hdr_pay(d, dst)));
          sent = g;
          if (l) mpkt++; else mstate = 1;
        end
      end else if (mstate == 1) begin
        exp_q.push_back(mk_flit(0, l, mvc, d));
        sent = mvc;
        if (l) begin mpkt++; mstate = 0; end
      end else if (l) mstate = 0;
    end
    for (int k = 0; k < V; k++) begin
      if (sent == k && !cr[k]) mcnt[k]--;
      else if (sent != k && cr[k]) begin
        if (mcnt[k] == B) merr_frame = 1; else mcnt[k]++;
      end
    end
  endtask

  // One clock: drive at negedge, check status mid-cycle, update model on the edge.
  task automatic cycle(input bit v, input logic [31:0] d, input bit f, input bit l,
                       input int dst, input logic [V-1:0] cr, output bit acc);
    bit mr;
    s_valid = v; s_data = d; s_first = f; s_last = l; s_dest = dst[NCW-1:0]; credit_in = cr;
    #1;
    mr = m_ready(f);
    chk("s_ready", 64'(s_ready), 64'(mr));
    chk("busy", 64'(busy), 64'(mstate != 0));
    chk("err_dest", 64'(err_dest), 64'(merr_dest));
    chk("err_frame", 64'(err_frame), 64'(merr_frame));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(mpkt % (1 << CNTW)));
    acc = v && mr;
    @(posedge clk);
    m_step(acc, d, f, l, dst, cr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 0; s_first = 0; s_last = 0; credit_in = '0;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    chk("rst_flit_out", 64'(flit_out), 64'h0);
    chk("rst_flit_wr", 64'(flit_out_wr), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_errs", 64'({err_dest, err_frame}), 64'h0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'h0);
  endtask

  task automatic send_pkt(input int len, input int dst, input logic [V-1:0] cr, output int cyc);
    bit acc;
    int b;
    b = 0;
    cyc = 0;
    while (b < len && cyc < 100) begin
      cycle(1, $urandom, b == 0, b == len - 1, dst, cr, acc);
      if (acc) b++;
      cyc++;
    end
    if (b < len) chk("send_pkt_timeout", 64'(b), 64'(len));
  endtask

  initial begin
    bit acc;
    int b, cyc, n0, len, dst;
    logic [V-1:0] cr;
    m_reset();
    @(negedge clk);
    do_reset();

    // Reset mid-packet: header + 2 body flits of a 5-beat packet, then reset.
    b = 0;
    for (int i = 0; i < 10 && b < 3; i++) begin
      cycle(1, $urandom, b == 0, 1'b0, 3, '0, acc);
      if (acc) b++;
    end
    do_reset();

    // Single-flit packet from tile (0,0) to core 5.
    cycle(1, 32'hABCD0000, 1, 1, 5, '0, acc);
    chk("single_flit", 64'(flit_out), 64'({1'b1, 1'b1, 2'b01, 32'hABCD0006}));

    // 6-beat packet with no credit returns stalls after B flits.
    do_reset();
    n0 = n_wr; b = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, $urandom, b == 0, b == 5, 8, '0, acc);
      if (acc) b++;
    end
    chk("stall_after_B", 64'(n_wr - n0), 64'(B));
    for (int i = 0; i < 2; i++) begin
      cycle(1, $urandom, b == 0, b == 5, 8, 2'b01, acc);
      if (acc) b++;
    end
    for (int i = 0; i < 6 && b < 6; i++) begin
      cycle(1, $urandom, b == 0, b == 5, 8, '0, acc);
      if (acc) b++;
    end
    cycle(0, 0, 0, 0, 0, '0, acc);
    chk("after_refill", 64'(n_wr - n0), 64'h6);
    chk("tail_pkt_cnt", 64'(pkt_cnt), 64'h1);

    // VC0 drained: grant skips to VC1; once refilled, round-robin returns to VC0.
    do_reset();
    send_pkt(4, 1, '0, cyc);
    send_pkt(1, 2, '0, cyc);
    send_pkt(1, 4, '0, cyc);
    chk("skip_empty_vc", 64'(flit_out[FPAY +: V]), 64'(2'b10));
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 2'b01, acc);
    send_pkt(1, 6, '0, cyc);
    chk("rr_back_vc0", 64'(flit_out[FPAY +: V]), 64'(2'b01));

    // Out-of-range destination: consumed silently.
    do_reset();
    n0 = n_wr;
    send_pkt(3, 9, '0, cyc);
    cycle(0, 0, 0, 0, 0, '0, acc);
    chk("drop_no_flits", 64'(n_wr - n0), 64'h0);
    chk("drop_cycles", 64'(cyc), 64'h3);
    chk("drop_err_dest", 64'(err_dest), 64'h1);

    // Stray body beat in idle.
    do_reset();
    cycle(1, $urandom, 0, 0, 0, '0, acc);
    chk("stray_err_frame", 64'(err_frame), 64'h1);

    // Credit return with buffer full.
    do_reset();
    cycle(0, 0, 0, 0, 0, 2'b01, acc);
    chk("ovf_err_frame", 64'(err_frame), 64'h1);

    // Flit + same-VC credit every beat: count never drops, so no stall.
    do_reset();
    n0 = n_wr;
    send_pkt(5, 7, 2'b01, cyc);
    cycle(0, 0, 0, 0, 0, '0, acc);
    chk("credit_cancel_cycles", 64'(cyc), 64'h5);
    chk("credit_cancel_flits", 64'(n_wr - n0), 64'h5);

    // Randomized traffic.
    do_reset();
    for (int p = 0; p < 300; p++) begin
      cur_x = XW'($urandom_range(0, NX - 1));
      cur_y = YW'($urandom_range(0, NY - 1));
      if ($urandom_range(0, 19) == 0) cycle(1, $urandom, 0, 1'($urandom), 0, '0, acc);
      if ($urandom_range(0, 59) == 0) do_reset();
      len = $urandom_range(1, 5);
      dst = $urandom_range(0, NC + 1);
      b = 0;
      for (int i = 0; i < 200 && b < len; i++) begin
        cr = '0;
        for (int k = 0; k < V; k++) cr[k] = (mcnt[k] < B) && ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 299) == 0) cr = '1;
        cycle($urandom_range(0, 3) != 0, $urandom, (b == 0) || ($urandom_range(0, 7) == 0),
              b == len - 1, dst, cr, acc);
        if (acc) b++;
      end
      if (b < len) chk("rand_timeout", 64'(b), 64'(len));
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, '0, acc);
    chk("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
